// File: rtl/shift_reg_unit_if.sv
// Command/result bundle between the multicycle control unit and the iterative shifter.
// The control unit is the master: it drives the command, load value and amount, and watches busy/done.
interface shift_reg_unit_if;
   logic [2:0]  w_ShiftCtrl;
   logic [31:0] w_ShiftIn;
   logic [4:0]  w_ShiftN;
   logic [31:0] w_ShiftReg;
   logic        w_ShiftBusy;
   logic        w_ShiftDone;

   modport master (
      output w_ShiftCtrl,
      output w_ShiftIn,
      output w_ShiftN,
      input  w_ShiftReg,
      input  w_ShiftBusy,
      input  w_ShiftDone
   );

   modport slave (
      input  w_ShiftCtrl,
      input  w_ShiftIn,
      input  w_ShiftN,
      output w_ShiftReg,
      output w_ShiftBusy,
      output w_ShiftDone
   );
endinterface

// File: rtl/shift_reg_unit.sv
// Iterative 32-bit shifter/rotator, one bit per cycle; LOAD latency 1, shift by N takes N+1 busy cycles.
// No backpressure: commands are only accepted in IDLE and ignored while busy or in the DONE pulse cycle.
module shift_reg_unit (
   input  logic             clk,
   input  logic             reset,
   shift_reg_unit_if.slave  sif
);

   localparam logic [2:0] CMD_NOP  = 3'b000;
   localparam logic [2:0] CMD_LOAD = 3'b001;
   localparam logic [2:0] CMD_SLL  = 3'b010;
   localparam logic [2:0] CMD_SRL  = 3'b011;
   localparam logic [2:0] CMD_SRA  = 3'b100;
   localparam logic [2:0] CMD_ROR  = 3'b101;
   localparam logic [2:0] CMD_ROL  = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t      state_q;
   logic [31:0] d_q;
   logic [4:0]  a_q;
   logic [4:0]  c_q;
   logic [2:0]  op_q;
   logic        busy_q;
   logic        done_q;

   function automatic logic [31:0] one_step(input logic [31:0] d, input logic [2:0] op);
      logic [31:0] r;
      case (op)
         CMD_SLL: r = {d[30:0], 1'b0};
         CMD_SRL: r = {1'b0, d[31:1]};
         CMD_SRA: r = {d[31], d[31:1]};
         CMD_ROR: r = {d[0], d[31:1]};
         CMD_ROL: r = {d[30:0], d[31]};
         default: r = d;
      endcase
      return r;
   endfunction

   logic is_shift_cmd;
   assign is_shift_cmd = (sif.w_ShiftCtrl >= CMD_SLL) && (sif.w_ShiftCtrl <= CMD_ROL);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         d_q     <= '0;
         a_q     <= '0;
         c_q     <= '0;
         op_q    <= CMD_NOP;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (sif.w_ShiftCtrl == CMD_LOAD) begin
                  d_q <= sif.w_ShiftIn;
                  a_q <= sif.w_ShiftN;
               end else if (is_shift_cmd) begin
                  busy_q <= 1'b1;
                  if (a_q != 5'd0) begin
                     op_q    <= sif.w_ShiftCtrl;
                     c_q     <= a_q;
                     state_q <= ST_SHIFT;
                  end else begin
                     // Zero amount: nothing to step, go straight to the done pulse.
                     done_q  <= 1'b1;
                     state_q <= ST_DONE;
                  end
               end
            end
            ST_SHIFT: begin
               d_q <= one_step(d_q, op_q);
               c_q <= c_q - 5'd1;
               if (c_q == 5'd1) begin
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign sif.w_ShiftReg  = d_q;
   assign sif.w_ShiftBusy = busy_q;
   assign sif.w_ShiftDone = done_q;

endmodule

// File: tb/tb_shift_reg_unit.sv
// Randomised and directed bench for shift_reg_unit against an arithmetic shift/rotate model.
module tb_shift_reg_unit;

   localparam logic [2:0] CMD_NOP  = 3'b000;
   localparam logic [2:0] CMD_LOAD = 3'b001;
   localparam logic [2:0] CMD_SLL  = 3'b010;
   localparam logic [2:0] CMD_SRL  = 3'b011;
   localparam logic [2:0] CMD_SRA  = 3'b100;
   localparam logic [2:0] CMD_ROR  = 3'b101;
   localparam logic [2:0] CMD_ROL  = 3'b110;
   localparam logic [2:0] CMD_NOP7 = 3'b111;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   shift_reg_unit_if sif ();

   shift_reg_unit dut (
      .clk   (clk),
      .reset (reset),
      .sif   (sif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] ref_shift(input logic [31:0] v, input logic [2:0] op, input int n);
      logic [31:0] r;
      if (n == 0) return v;
      case (op)
         CMD_SLL: r = v << n;
         CMD_SRL: r = v >> n;
         CMD_SRA: r = $signed(v) >>> n;
         CMD_ROR: r = (v >> n) | (v << (32 - n));
         CMD_ROL: r = (v << n) | (v >> (32 - n));
         default: r = v;
      endcase
      return r;
   endfunction

   task automatic do_load(input logic [31:0] v, input logic [4:0] n);
      sif.w_ShiftCtrl = CMD_LOAD;
      sif.w_ShiftIn   = v;
      sif.w_ShiftN    = n;
      tick();
      sif.w_ShiftCtrl = CMD_NOP;
   endtask

   // Issues one command and measures the busy window; result sampled in the done cycle and after.
   task automatic run_shift(input logic [2:0] op, output int busy_cyc, output int done_cyc,
                            output int done_at, output logic [31:0] res_done, output logic [31:0] res_idle);
      sif.w_ShiftCtrl = op;
      tick();
      sif.w_ShiftCtrl = CMD_NOP;
      busy_cyc = 0;
      done_cyc = 0;
      done_at  = -1;
      res_done = 32'hxxxx_xxxx;
      while (sif.w_ShiftBusy === 1'b1 && busy_cyc < 64) begin
         if (sif.w_ShiftDone === 1'b1) begin
            done_cyc++;
            done_at  = busy_cyc;
            res_done = sif.w_ShiftReg;
         end
         busy_cyc++;
         tick();
      end
      if (busy_cyc >= 64) begin
         checks++;
         errors++;
         $display("FAIL busy_timeout: busy still high after %0d cycles, required to drop", busy_cyc);
      end
      res_idle = sif.w_ShiftReg;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      checks++;
      if (sif.w_ShiftReg !== 32'h0 || sif.w_ShiftBusy !== 1'b0 || sif.w_ShiftDone !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: reg=%h busy=%b done=%b, required 0/0/0",
                  sif.w_ShiftReg, sif.w_ShiftBusy, sif.w_ShiftDone);
      end
   endtask

   task automatic test_nop_and_load();
      do_load(32'hCAFE_0123, 5'd3);
      checks++;
      if (sif.w_ShiftReg !== 32'hCAFE_0123 || sif.w_ShiftBusy !== 1'b0 || sif.w_ShiftDone !== 1'b0) begin
         errors++;
         $display("FAIL load_latency: reg=%h busy=%b done=%b, required cafe0123/0/0",
                  sif.w_ShiftReg, sif.w_ShiftBusy, sif.w_ShiftDone);
      end
      sif.w_ShiftCtrl = CMD_NOP7;
      sif.w_ShiftIn   = 32'h5555_5555;
      tick();
      sif.w_ShiftCtrl = CMD_NOP;
      tick();
      checks++;
      if (sif.w_ShiftReg !== 32'hCAFE_0123 || sif.w_ShiftBusy !== 1'b0) begin
         errors++;
         $display("FAIL nop_hold: reg=%h busy=%b, required cafe0123/0", sif.w_ShiftReg, sif.w_ShiftBusy);
      end
   endtask

   task automatic test_sll_basic();
      int bc, dc, da;
      logic [31:0] rd, ri;
      do_load(32'h0000_00F1, 5'd4);
      run_shift(CMD_SLL, bc, dc, da, rd, ri);
      checks++;
      if (bc != 5 || dc != 1 || da != 4) begin
         errors++;
         $display("FAIL sll_timing: busy=%0d done=%0d done_at=%0d, required 5/1/4", bc, dc, da);
      end
      checks++;
      if (rd !== 32'h0000_0F10 || ri !== 32'h0000_0F10) begin
         errors++;
         $display("FAIL sll_result: done_val=%h idle_val=%h, required 00000f10", rd, ri);
      end
   endtask

   task automatic test_boundary_31();
      int bc, dc, da;
      logic [31:0] rd, ri;
      do_load(32'h8000_0000, 5'd31);
      run_shift(CMD_SRA, bc, dc, da, rd, ri);
      checks++;
      if (ri !== 32'hFFFF_FFFF || bc != 32 || dc != 1) begin
         errors++;
         $display("FAIL sra_31: val=%h busy=%0d done=%0d, required ffffffff/32/1", ri, bc, dc);
      end
      do_load(32'h8000_0000, 5'd31);
      run_shift(CMD_SRL, bc, dc, da, rd, ri);
      checks++;
      if (ri !== 32'h0000_0001 || bc != 32) begin
         errors++;
         $display("FAIL srl_31: val=%h busy=%0d, required 00000001/32", ri, bc);
      end
      do_load(32'h0000_0001, 5'd31);
      run_shift(CMD_SLL, bc, dc, da, rd, ri);
      checks++;
      if (ri !== 32'h8000_0000) begin
         errors++;
         $display("FAIL sll_31: val=%h, required 80000000", ri);
      end
   endtask

   task automatic test_rotate_retain();
      int bc, dc, da;
      logic [31:0] rd, ri;
      do_load(32'h0000_0001, 5'd1);
      run_shift(CMD_ROR, bc, dc, da, rd, ri);
      checks++;
      if (ri !== 32'h8000_0000 || bc != 2 || da != 1) begin
         errors++;
         $display("FAIL ror_1: val=%h busy=%0d done_at=%0d, required 80000000/2/1", ri, bc, da);
      end
      run_shift(CMD_ROL, bc, dc, da, rd, ri);
      checks++;
      if (ri !== 32'h0000_0001 || bc != 2) begin
         errors++;
         $display("FAIL rol_retained: val=%h busy=%0d, required 00000001/2", ri, bc);
      end
   endtask

   task automatic test_zero_amount();
      int bc, dc, da;
      logic [31:0] rd, ri;
      do_load(32'hDEAD_BEEF, 5'd0);
      run_shift(CMD_SLL, bc, dc, da, rd, ri);
      checks++;
      if (bc != 1 || dc != 1 || da != 0 || rd !== 32'hDEAD_BEEF || ri !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL zero_amount: busy=%0d done=%0d at=%0d val=%h, required 1/1/0/deadbeef",
                  bc, dc, da, ri);
      end
   endtask

   task automatic test_ignored_cmds();
      int bc;
      logic [31:0] after;
      do_load(32'h0000_00FF, 5'd8);
      sif.w_ShiftCtrl = CMD_SRL;
      tick();
      sif.w_ShiftCtrl = CMD_LOAD;
      sif.w_ShiftIn   = 32'h1111_1111;
      sif.w_ShiftN    = 5'd2;
      bc = 0;
      while (sif.w_ShiftBusy === 1'b1 && bc < 64) begin
         bc++;
         tick();
      end
      after = sif.w_ShiftReg;
      checks++;
      if (after !== 32'h0 || bc != 9) begin
         errors++;
         $display("FAIL load_ignored_busy: val=%h busy=%0d, required 00000000/9", after, bc);
      end
      tick();
      sif.w_ShiftCtrl = CMD_NOP;
      checks++;
      if (sif.w_ShiftReg !== 32'h1111_1111) begin
         errors++;
         $display("FAIL load_after_idle: val=%h, required 11111111", sif.w_ShiftReg);
      end
   endtask

   task automatic test_reset_midshift();
      int bc, dc, da;
      logic [31:0] rd, ri;
      do_load(32'h1234_5678, 5'd8);
      sif.w_ShiftCtrl = CMD_SLL;
      tick();
      sif.w_ShiftCtrl = CMD_NOP;
      tick();
      tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      checks++;
      if (sif.w_ShiftReg !== 32'h0 || sif.w_ShiftBusy !== 1'b0 || sif.w_ShiftDone !== 1'b0) begin
         errors++;
         $display("FAIL reset_midshift: reg=%h busy=%b done=%b, required 0/0/0",
                  sif.w_ShiftReg, sif.w_ShiftBusy, sif.w_ShiftDone);
      end
      tick();
      checks++;
      if (sif.w_ShiftDone !== 1'b0 || sif.w_ShiftBusy !== 1'b0) begin
         errors++;
         $display("FAIL reset_no_done: busy=%b done=%b, required 0/0", sif.w_ShiftBusy, sif.w_ShiftDone);
      end
      run_shift(CMD_SRA, bc, dc, da, rd, ri);
      checks++;
      if (bc != 1 || dc != 1 || ri !== 32'h0) begin
         errors++;
         $display("FAIL reset_amount_cleared: busy=%0d done=%0d val=%h, required 1/1/0", bc, dc, ri);
      end
   endtask

   // Random loads and shifts, with occasional repeats that reuse the retained amount.
   task automatic test_back_to_back();
      logic [31:0] md, rd, ri, exp;
      int ma, bc, dc, da;
      logic [2:0] op;
      md = sif.w_ShiftReg;
      ma = 0;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) != 0) begin
            md = $urandom;
            ma = $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) ma = 31;
            do_load(md, ma[4:0]);
         end
         op  = 3'($urandom_range(2, 6));
         exp = ref_shift(md, op, ma);
         run_shift(op, bc, dc, da, rd, ri);
         checks++;
         if (ri !== exp || rd !== exp || bc != ma + 1 || dc != 1 || da != ma) begin
            errors++;
            $display("FAIL rand_%0d op=%0d n=%0d: val=%h done_val=%h busy=%0d done=%0d at=%0d, required %h/%0d/1/%0d",
                     i, op, ma, ri, rd, bc, dc, da, exp, ma + 1, ma);
         end
         md = exp;
      end
   endtask

   initial begin
      reset           = 1'b0;
      sif.w_ShiftCtrl = CMD_NOP;
      sif.w_ShiftIn   = '0;
      sif.w_ShiftN    = '0;
      test_reset();
      test_nop_and_load();
      test_sll_basic();
      test_boundary_31();
      test_rotate_retain();
      test_zero_amount();
      test_ignored_cmds();
      test_reset_midshift();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_reg_unit.md
# shift_reg_unit

Iterative 32-bit shift register that produces the `w_ShiftReg` operand for the multicycle datapath's write-back select (code 3'b010). The control unit loads it with a value and a 5-bit amount, then issues one shift or rotate command. The unit moves one bit position per cycle under a busy/done handshake, so the control FSM can wait on `w_ShiftDone` before selecting the result for register write-back.

## Interface
- No parameters. Data width is fixed at 32 and amount width at 5.
- `clk` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: synchronous, active-low. Sampled on the rising edge of `clk`.
- `w_ShiftCtrl` input 3: command. 000 NOP, 001 LOAD, 010 SLL, 011 SRL, 100 SRA, 101 ROR, 110 ROL, 111 NOP.
- `w_ShiftIn` input 32: value captured by LOAD (rt, or rs for variable forms, as chosen by the control unit).
- `w_ShiftN` input 5: shift amount captured by LOAD (shamt or rs[4:0]).
- `w_ShiftReg` output 32: current register contents, registered.
- `w_ShiftBusy` output 1: high when the state is not IDLE.
- `w_ShiftDone` output 1: one-cycle pulse; high only in the DONE state.

## Operation
- Internal state:
  - data register D (32 bits), drives `w_ShiftReg`
  - amount register A (5 bits)
  - down-counter C (5 bits)
  - latched op OP (3 bits)
  - FSM states IDLE, SHIFT, DONE
- Reset (`reset`=0 at an edge): D=0, A=0, C=0, OP=NOP, state IDLE. All outputs read 0 the cycle after. Reset takes priority in every state and aborts any shift in progress.
- IDLE:
  - NOP or 111: no change.
  - LOAD: D←`w_ShiftIn`, A←`w_ShiftN`, stay IDLE. No done pulse.
  - Shift/rotate code with A≠0: OP←code, C←A, go to SHIFT.
  - Shift/rotate code with A=0: D unchanged, go directly to DONE.
- SHIFT: each edge applies one 1-bit step to D according to OP and decrements C. On the edge where C goes 1→0, go to DONE. `w_ShiftCtrl` is ignored.
  - SLL: D←{D[30:0],0}
  - SRL: D←{0,D[31:1]}
  - SRA: D←{D[31],D[31:1]}
  - ROR: D←{D[0],D[31:1]}
  - ROL: D←{D[30:0],D[31]}
- DONE: assert `w_ShiftDone`, hold D, return to IDLE on the next edge unconditionally. Commands presented in DONE are ignored.
- A is retained after a shift. Issuing a second shift command without a new LOAD repeats the same amount on the already-shifted D.
- Total shift equals A exactly: N single-bit steps give the same result as an N-bit barrel shift. SRA of a negative value saturates to 0xFFFF_FFFF. SLL/SRL by 31 leave a single surviving bit.

## Timing
- LOAD: D and A are visible on `w_ShiftReg` the cycle after the sampling edge. Latency 1.
- Shift command sampled at edge E0 with A=N>0:
  - `w_ShiftBusy`=1 from after E0.
  - D updates at edges E1..EN; the final result is valid after EN.
  - `w_ShiftDone`=1 for exactly the cycle between EN and EN+1.
  - Busy deasserts after EN+1. Busy is high for N+1 cycles in total.
- Shift command with A=0: busy and done are both high for exactly one cycle after E0. D is unchanged.
- The earliest next accepted command is at edge EN+1 (IDLE sampled).
- The result is stable from DONE onward and stays stable through IDLE until the next LOAD or shift. The write-back select may sample it in the DONE cycle or any later cycle.
- Reset asserted mid-SHIFT: after that edge, state is IDLE, D=0, and busy, done and `w_ShiftReg` are all 0. There is no done pulse for the aborted shift.

## Test plan
- Reset while in SHIFT with D=0x1234_5678 → next cycle `w_ShiftReg`=0, `w_ShiftBusy`=0, `w_ShiftDone`=0. A following shift with A=0 gives an immediate done and D stays 0.
- LOAD 0x0000_00F1, N=4, then SLL → busy for 5 cycles, done pulse exactly 1 cycle after the 4th step, `w_ShiftReg`=0x0000_0F10.
- LOAD 0x8000_0000, N=31, then SRA → 0xFFFF_FFFF after 31 steps. Reload the same value and N, then SRL → 0x0000_0001.
- LOAD 0x0000_0001, N=1, then ROR → 0x8000_0000. Then ROL without reloading → 0x0000_0001, reusing the retained A=1.
- LOAD 0xDEAD_BEEF, N=0, then SLL → done and busy high for one cycle after the command, `w_ShiftReg` unchanged at 0xDEAD_BEEF.
- LOAD 0x0000_00FF, N=8, SRL started, then LOAD 0x1111_1111 presented mid-shift and in the DONE cycle → both ignored, final `w_ShiftReg`=0x0000_0000. A LOAD sampled in IDLE afterwards takes effect.
